// File: rtl/mole_controller.sv
// Whack-a-mole engine: one LFSR-chosen mole at a time, hit/miss judging, saturating 8-bit score.
// Latency: every output registered, one cycle after the sampling edge; no backpressure, btn_hit pulses are consumed as they arrive.
module mole_controller #(
  parameter int MS_CYCLES = 100000,
  parameter int GAP_MS    = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_mole_ctrl,
  input  logic       enable_score,
  input  logic       clear_score,
  input  logic [1:0] difficulty_level,
  input  logic [7:0] btn_hit,
  output logic [7:0] mole_leds,
  output logic [7:0] score,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam logic [31:0] GAP_LAST = 32'(GAP_MS * MS_CYCLES - 1);
  localparam logic [31:0] UP0_LAST = 32'(1000 * MS_CYCLES - 1);
  localparam logic [31:0] UP1_LAST = 32'(750 * MS_CYCLES - 1);
  localparam logic [31:0] UP2_LAST = 32'(500 * MS_CYCLES - 1);
  localparam logic [31:0] UP3_LAST = 32'(300 * MS_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q;
  logic        lfsr_fb;
  logic [2:0]  prev_hole_q, prev_hole_d, pick;
  logic [31:0] timer_q, timer_d;
  logic [31:0] up_last_q, up_last_d, up_last_sel;
  logic [7:0]  mole_d, score_d;
  logic        hit_d, miss_d, inc;
  logic        hit_now, wrong_now;

  // Taps 16,14,13,11 in the right-shifting Fibonacci form.
  assign lfsr_fb   = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign pick      = (lfsr_q[2:0] == prev_hole_q) ? lfsr_q[2:0] + 3'd1 : lfsr_q[2:0];
  assign hit_now   = |(btn_hit & mole_leds);
  assign wrong_now = |(btn_hit & ~mole_leds);

  always_comb begin
    up_last_sel = UP0_LAST;
    case (difficulty_level)
      2'd0: up_last_sel = UP0_LAST;
      2'd1: up_last_sel = UP1_LAST;
      2'd2: up_last_sel = UP2_LAST;
      2'd3: up_last_sel = UP3_LAST;
      default: up_last_sel = UP0_LAST;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    up_last_d   = up_last_q;
    prev_hole_d = prev_hole_q;
    mole_d      = mole_leds;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    inc         = 1'b0;
    if (!enable_mole_ctrl) begin
      state_d = IDLE;
      timer_d = '0;
      mole_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          timer_d = '0;
        end
        GAP: begin
          if (timer_q == GAP_LAST) begin
            state_d     = UP;
            timer_d     = '0;
            prev_hole_d = pick;
            mole_d      = 8'd1 << pick;
            up_last_d   = up_last_sel;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        UP: begin
          if (hit_now) begin
            hit_d   = 1'b1;
            inc     = enable_score;
            state_d = GAP;
            timer_d = '0;
            mole_d  = '0;
          end else if (wrong_now) begin
            // The timer parks at its last value so a press on the expiry cycle defers, not cancels, the timeout.
            miss_d = 1'b1;
            if (timer_q != up_last_q) timer_d = timer_q + 32'd1;
          end else if (timer_q == up_last_q) begin
            miss_d  = 1'b1;
            state_d = GAP;
            timer_d = '0;
            mole_d  = '0;
          end else begin
            timer_d = timer_q + 32'd1;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
          mole_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    score_d = score;
    if (clear_score)                 score_d = '0;
    else if (inc && score != 8'hFF)  score_d = score + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lfsr_q      <= 16'hACE1;
      prev_hole_q <= '0;
      timer_q     <= '0;
      up_last_q   <= '0;
      mole_leds   <= '0;
      score       <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= {lfsr_fb, lfsr_q[15:1]};
      prev_hole_q <= prev_hole_d;
      timer_q     <= timer_d;
      up_last_q   <= up_last_d;
      mole_leds   <= mole_d;
      score       <= score_d;
      hit_pulse   <= hit_d;
      miss_pulse  <= miss_d;
    end
  end

endmodule

// File: tb/tb_mole_controller.sv
// Bench for mole_controller: event-time reference model checked every cycle, plus table-driven and directed corner cases.
module tb_mole_controller;

  localparam int MS    = 10;
  localparam int GAPMS = 2;
  localparam int G     = GAPMS * MS;

  logic       clk = 1'b0;
  logic       rst, en, es, clr;
  logic [1:0] diff;
  logic [7:0] btn;
  logic [7:0] leds, score;
  logic       hit, miss;

  int n_vec = 0;
  int n_err = 0;

  mole_controller #(.MS_CYCLES(MS), .GAP_MS(GAPMS)) dut (
    .clk(clk), .rst(rst), .enable_mole_ctrl(en), .enable_score(es),
    .clear_score(clr), .difficulty_level(diff), .btn_hit(btn),
    .mole_leds(leds), .score(score), .hit_pulse(hit), .miss_pulse(miss)
  );

  always #5 clk = ~clk;

  // Reference model: absolute-time schedule of the next pop or timeout.
  int          up_ms [4] = '{1000, 750, 500, 300};
  longint      now     = 0;
  bit          m_run   = 0;
  int          m_hole  = -1;
  longint      m_due   = 0;
  int          m_prev  = 0;
  int          m_score = 0;
  bit          m_hit   = 0;
  bit          m_miss  = 0;
  logic [15:0] m_lfsr  = 16'hACE1;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  function automatic int hole_of(input logic [7:0] l);
    for (int i = 0; i < 8; i++) if (l[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int cand;
    m_hit  = 0;
    m_miss = 0;
    if (rst) begin
      m_run = 0; m_hole = -1; m_prev = 0; m_score = 0; m_lfsr = 16'hACE1;
      return;
    end
    if (!en) begin
      m_run = 0; m_hole = -1;
    end else if (!m_run) begin
      m_run = 1; m_hole = -1; m_due = now + G;
    end else if (m_hole < 0) begin
      if (now == m_due) begin
        cand = int'(m_lfsr[2:0]);
        if (cand == m_prev) cand = (cand + 1) % 8;
        m_hole = cand;
        m_prev = cand;
        m_due  = now + up_ms[diff] * MS;
      end
    end else if (btn[m_hole]) begin
      m_hit = 1; m_hole = -1; m_due = now + G;
      if (es && m_score < 255) m_score++;
    end else if (btn != 8'h00) begin
      m_miss = 1;
    end else if (now >= m_due) begin
      m_miss = 1; m_hole = -1; m_due = now + G;
    end
    if (clr) m_score = 0;
    m_lfsr = lfsr_adv(m_lfsr);
    now++;
  endtask

  task automatic step();
    logic [7:0] e_leds;
    logic [7:0] e_score;
    model_edge();
    @(posedge clk);
    #1;
    e_leds  = (m_hole < 0) ? 8'h00 : 8'(1 << m_hole);
    e_score = 8'(m_score);
    n_vec++;
    if (leds !== e_leds || score !== e_score || hit !== m_hit || miss !== m_miss) begin
      n_err++;
      if (n_err < 20)
        $display("FAIL model t=%0d: leds=%h score=%0d hit=%b miss=%b, expected leds=%h score=%0d hit=%b miss=%b",
                 now, leds, score, hit, miss, e_leds, e_score, m_hit, m_miss);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_mole(input int limit, output int n);
    n = 0;
    while (leds == 8'h00 && n < limit) begin
      step();
      n++;
    end
    check("mole_appears", int'(leds != 8'h00), 1);
  endtask

  task automatic count_up(output int n);
    n = 0;
    while (leds != 8'h00 && n < 20000) begin
      step();
      n++;
    end
  endtask

  task automatic press(input logic [7:0] b);
    btn = b;
    step();
    btn = 8'h00;
  endtask

  typedef struct {
    int bk;   // 0 none, 1 correct, 2 wrong, 3 correct+wrong
    bit es;
    bit clr;
    bit eh;
    bit em;
    int esc;
    bit eup;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, moles, last_hole;
    logic [7:0] prev_leds, b;

    tbl[0] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[1] = '{1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0};
    tbl[2] = '{2, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b1};
    tbl[3] = '{3, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0};
    tbl[4] = '{0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1};
    tbl[5] = '{1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0};
    tbl[6] = '{2, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[7] = '{1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};

    // Reset with all inputs toggling.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      en = 1'($urandom); es = 1'($urandom); clr = 1'($urandom);
      diff = 2'($urandom); btn = 8'($urandom);
      step();
    end
    check("reset_outputs", int'({leds, score, hit, miss}), 0);
    rst = 1'b0; en = 1'b0; es = 1'b0; clr = 1'b0; diff = 2'd0; btn = 8'h00;
    step();

    // First mole from the seed, full timeout at difficulty 0.
    en = 1'b1;
    wait_mole(G + 100, n);
    check("first_gap_len", n, G + 1);
    count_up(n);
    check("up_len_d0", n, 1000 * MS);
    check("timeout_miss", int'(miss), 1);
    check("timeout_score", int'(score), 0);
    step();
    check("miss_one_cycle", int'(miss), 0);

    // Up-time per difficulty; a change mid-UP must not matter.
    for (int d = 1; d < 4; d++) begin
      diff = 2'(d);
      wait_mole(G + 100, n);
      diff = 2'(d + 1);
      count_up(n);
      check($sformatf("up_len_d%0d", d), n, up_ms[d] * MS);
      check($sformatf("timeout_miss_d%0d", d), int'(miss), 1);
    end

    // Hit / wrong-hole / clear table.
    diff = 2'd3;
    for (int i = 0; i < 8; i++) begin
      wait_mole(G + 100, n);
      h = hole_of(leds);
      b = 8'h00;
      if (tbl[i].bk == 1 || tbl[i].bk == 3) b = b | 8'(1 << h);
      if (tbl[i].bk == 2 || tbl[i].bk == 3) b = b | 8'(1 << ((h + 3) % 8));
      es = tbl[i].es; clr = tbl[i].clr;
      press(b);
      clr = 1'b0;
      check($sformatf("tbl%0d_hit", i), int'(hit), int'(tbl[i].eh));
      check($sformatf("tbl%0d_miss", i), int'(miss), int'(tbl[i].em));
      check($sformatf("tbl%0d_score", i), int'(score), tbl[i].esc);
      check($sformatf("tbl%0d_up", i), int'(leds != 8'h00), int'(tbl[i].eup));
    end

    // Drive the score to saturation, then clear on a hit.
    es = 1'b1;
    for (int i = 0; i < 254; i++) begin
      wait_mole(G + 100, n);
      press(leds);
    end
    check("score_255", int'(score), 255);
    wait_mole(G + 100, n);
    press(leds);
    check("sat_hold", int'(score), 255);
    check("sat_hit", int'(hit), 1);
    wait_mole(G + 100, n);
    clr = 1'b1;
    press(leds);
    clr = 1'b0;
    check("clear_over_inc", int'(score), 0);
    check("clear_hit", int'(hit), 1);

    // Disable mid-UP coinciding with a correct press.
    wait_mole(G + 100, n);
    step(); step();
    en = 1'b0;
    press(leds);
    check("dis_leds", int'(leds), 0);
    check("dis_pulses", int'({hit, miss}), 0);
    check("dis_score", int'(score), 0);
    step(); step(); step();
    en = 1'b1;
    wait_mole(G + 100, n);
    check("reenable_gap_len", n, G + 1);

    // Randomized run over 200 moles.
    moles = 0;
    last_hole = hole_of(leds);
    prev_leds = leds;
    for (int cyc = 0; cyc < 40000 && moles < 200; cyc++) begin
      es   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) diff = 2'($urandom);
      en   = ($urandom_range(0, 499) != 0);
      b = 8'h00;
      if (leds != 8'h00 && $urandom_range(0, 5) == 0) b = leds;
      if ($urandom_range(0, 39) == 0) b = b | 8'($urandom);
      btn = b;
      step();
      btn = 8'h00;
      if (leds != 8'h00 && prev_leds == 8'h00) begin
        moles++;
        check("rand_onehot", int'($countones(leds)), 1);
        check("rand_no_repeat", int'(hole_of(leds) != last_hole), 1);
        last_hole = hole_of(leds);
      end
      prev_leds = leds;
    end
    check("rand_mole_count", moles, 200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Responder to the game control FSM's `enable_mole_ctrl`, `enable_score`, `clear_score` and `difficulty_level` outputs, and producer of the `score` value that the FSM displays. While enabled, it pops one pseudo-random mole (LED) at a time for a difficulty-dependent window and judges the per-hole hit buttons. It counts hits into an 8-bit saturating score and emits one-cycle hit and miss pulses for audio and feedback logic.

## Interface
- `MS_CYCLES`, default 100000: clock cycles per millisecond. Benches use 10.
- `GAP_MS`, default 250: off-time in ms between moles.
- `clk`  input  1: system clock.
- `rst`  input  1: synchronous, active-high reset.
- `enable_mole_ctrl`  input  1: level signal. High runs the mole sequence; low forces IDLE.
- `enable_score`  input  1: level signal. A hit increments the score only while this is high.
- `clear_score`  input  1: level signal. While high, score is held at 0.
- `difficulty_level`  input  2: selects the mole up-time. It is sampled on each entry to UP.
- `btn_hit`  input  8: one-cycle pulses, one bit per hole, from button_io.
- `mole_leds`  output  8: one-hot active mole, or all zeros.
- `score`  output  8: hit count, saturating at 255.
- `hit_pulse`  output  1: one-cycle pulse on a correct hit.
- `miss_pulse`  output  1: one-cycle pulse on a wrong-hole press or a timeout.

## Operation
- **States:** IDLE, GAP, UP.
- **Reset:**
  - state = IDLE.
  - `mole_leds` = 0, `score` = 0, `hit_pulse` = 0, `miss_pulse` = 0.
  - LFSR = 16'hACE1, `prev_hole` = 0, both timers = 0.
- **LFSR:** 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Shifts every cycle in every state except reset.
  - Candidate hole = `lfsr[2:0]`. If the candidate equals `prev_hole`, use (candidate+1) mod 8. Consecutive moles never share a hole.
- **IDLE:**
  - `mole_leds` = 0 and all `btn_hit` input is ignored.
  - `enable_mole_ctrl` high → GAP, with the timers cleared.
- **GAP:**
  - `mole_leds` = 0 and `btn_hit` is ignored.
  - After `GAP_MS`·`MS_CYCLES` cycles → UP.
  - On that transition: pick the hole, latch `prev_hole`, set `mole_leds` one-hot, latch the up-time and clear the timers.
- **Up-time by `difficulty_level`:** 0 → 1000 ms, 1 → 750 ms, 2 → 500 ms, 3 → 300 ms. A `difficulty_level` change during UP has no effect until the next mole.
- **UP** (priority order, evaluated each cycle):
  1. `btn_hit & mole_leds` ≠ 0 is a hit. Effects:
     - `hit_pulse` = 1 and `score` increments if `enable_score` is high.
     - → GAP and `mole_leds` = 0.
     - A wrong bit pressed in the same cycle is ignored: no miss is reported.
  2. `btn_hit & ~mole_leds` ≠ 0 is a wrong-hole press. `miss_pulse` = 1; state, mole and score are unchanged.
  3. The up-time expires with no hit (timeout). `miss_pulse` = 1, → GAP, `mole_leds` = 0.
- **Score:**
  - `clear_score` has priority over an increment in the same cycle: the result is 0.
  - An increment at 255 holds at 255.
  - Score is never decremented.
  - Score is not cleared by `enable_mole_ctrl` falling. It holds through the FSM's game-over state.
- **Disable:** `enable_mole_ctrl` low in any state has these effects:
  - → IDLE and `mole_leds` = 0.
  - No hit or miss pulse is generated, even if `btn_hit` or a timeout coincides.
  - The timers clear.

## Timing
- All outputs are registered. The input condition is sampled at edge N and the response is visible in the cycle after edge N.
- `hit_pulse` and `miss_pulse` are high for exactly one cycle per event.
- GAP lasts exactly `GAP_MS`·`MS_CYCLES` cycles from the entry edge to the UP-entry edge.
- UP lasts exactly up_ms·`MS_CYCLES` cycles when no hit occurs. The timeout edge sets `miss_pulse` and clears `mole_leds` together.
- From `enable_mole_ctrl` rising (IDLE) to the first mole: 1 cycle into GAP, plus the GAP duration.
- Re-enabling after a disable always starts with a full GAP.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all inputs toggling → every output reads 0. The first mole after enable is derived from LFSR seed 16'hACE1.
- **Timeout** (`MS_CYCLES`=10, `difficulty_level`=0): `enable_mole_ctrl`=1 → a one-hot `mole_leds` appears 2500 cycles after entering GAP and stays 10000 cycles. Then `miss_pulse`=1 for 1 cycle, `mole_leds`=0 and score stays 0.
- **Hit** (`enable_score`=1): `btn_hit` equal to the active hole → next cycle `hit_pulse`=1, `score`=1 and `mole_leds`=0. The same hit with `enable_score`=0 gives `hit_pulse`=1 and `score`=0.
- **Wrong-hole press:** press a wrong hole → `miss_pulse`=1 and the mole stays up. Then press correct and wrong bits in the same cycle → `hit_pulse` only, no `miss_pulse`.
- **Score boundaries:** preload the score to 255 via 255 hits, then hit again → score stays 255. Next, hit with `clear_score`=1 in the same cycle → score 0 and `hit_pulse` still 1.
- **Disable and sequence:** drop `enable_mole_ctrl` mid-UP while coinciding with `btn_hit` → IDLE, `mole_leds`=0 and no pulses. Over 200 consecutive moles, no hole repeats back-to-back and every `difficulty_level` value gives the correct up-time.
